// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator request port.
package calc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // True for the two shift commands, which use the shifter latency.
  function automatic logic is_shift_cmd(input logic [3:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

  // True for add/sub, which use the adder latency.
  function automatic logic is_arith_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational 32-bit unsigned add/sub/shift unit.
// err flags add carry-out, subtract underflow and any unknown command;
// result is forced to 0 whenever err is set.
module calc_alu
  import calc_pkg::*;
(
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [DATA_W:0] sum;

  // Widened sum so the carry-out is visible as the top bit.
  assign sum = {1'b0, op1} + {1'b0, op2};

  // Select the operation; only op2[4:0] is a shift amount.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (cmd)
      CMD_ADD: begin
        err    = sum[DATA_W];
        result = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
      end
      CMD_SUB: begin
        err    = (op2 > op1);
        result = (op2 > op1) ? '0 : (op1 - op2);
      end
      CMD_SHL: result = op1 << op2[4:0];
      CMD_SHR: result = op1 >> op2[4:0];
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_port_engine.sv
// calc_port_engine: responder for one calculator request port.
// Command + operand1 in one cycle, operand2 the next, fixed-latency
// execute, then a single-cycle registered response.
// Optional build macro: CALC_PORT_ERRCNT_EN adds the saturating
// proto_err_cnt output counting commands issued while EXEC/RESP.
module calc_port_engine
  import calc_pkg::*;
#(
  parameter int ADD_LAT   = 2,
  parameter int SHIFT_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef CALC_PORT_ERRCNT_EN
  ,
  output logic [7:0]        proto_err_cnt
`endif
);

  localparam int CNT_W = 16;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         cmd_q;
  logic [DATA_W-1:0]  op1_q;
  logic [DATA_W-1:0]  op2_q;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_err;
  logic [1:0]         resp_d;
  logic [DATA_W-1:0]  data_d;
  logic               busy_d;
  logic               exec_done;

  calc_alu u_alu (
    .cmd    (cmd_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (alu_res),
    .err    (alu_err)
  );

  // Last EXEC cycle: result is captured into the output registers here.
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; commands outside IDLE never redirect the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_cmd_in != 4'd0) state_d = ST_OP2;
      ST_OP2:  state_d = ST_EXEC;
      ST_EXEC: if (exec_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next output values; the ALU error flag also covers unknown commands.
  always_comb begin
    resp_d = RESP_NONE;
    data_d = '0;
    busy_d = (state_d != ST_IDLE);
    if (exec_done) begin
      if (alu_err) begin
        resp_d = RESP_ERR;
      end else begin
        resp_d = RESP_OK;
        data_d = alu_res;
      end
    end
  end

  // Output registers; the response lives only for the RESP cycle.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      out_resp <= resp_d;
      out_data <= data_d;
      busy     <= busy_d;
    end
  end

  // Operand capture: command/op1 on acceptance, op2 in the OP2 cycle.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q <= 4'd0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && (req_cmd_in != 4'd0)) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
      end
      if (state_q == ST_OP2) op2_q <= req_data_in;
    end
  end

  // Latency counter; an unknown command runs a single EXEC cycle so its
  // error response lands one cycle after operand2, like a 1-cycle op.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_OP2) begin
      if (is_shift_cmd(cmd_q))      cnt_q <= CNT_W'(SHIFT_LAT);
      else if (is_arith_cmd(cmd_q)) cnt_q <= CNT_W'(ADD_LAT);
      else                          cnt_q <= CNT_W'(1);
    end else if ((state_q == ST_EXEC) && !exec_done) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef CALC_PORT_ERRCNT_EN
  logic viol;

  assign viol = ((state_q == ST_EXEC) || (state_q == ST_RESP)) &&
                (req_cmd_in != 4'd0);

  // Saturating count of commands issued while an operation is in flight.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset)                          proto_err_cnt <= 8'd0;
    else if (viol && (proto_err_cnt != 8'hFF)) proto_err_cnt <= proto_err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_calc_port_engine.sv
// Bench for calc_port_engine: directed transactions, a timeline-level
// reference model compared every cycle, and literal spot checks.
module tb_calc_port_engine;

  localparam int ADD_LAT   = 2;
  localparam int SHIFT_LAT = 3;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_cmd_in = 4'd0;
  logic [31:0] req_data_in = 32'd0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
`ifdef CALC_PORT_ERRCNT_EN
  logic [7:0]  proto_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  calc_port_engine #(.ADD_LAT(ADD_LAT), .SHIFT_LAT(SHIFT_LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
`ifdef CALC_PORT_ERRCNT_EN
    ,
    .proto_err_cnt (proto_err_cnt)
`endif
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (edge-numbered timeline) ----------------
  int          ecount = 0;
  logic        m_pend = 1'b0;
  int          m_c0 = 0;
  int          m_rcyc = 0;
  logic [3:0]  m_cmd = 4'd0;
  logic [31:0] m_op1 = 32'd0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] m_res = 32'd0;
  int          m_err = 0;
  logic [1:0]  e_resp = 2'd0;
  logic [31:0] e_data = 32'd0;
  logic        e_busy = 1'b0;

  function automatic int model_lat(input logic [3:0] c);
    if (c == 4'd1 || c == 4'd2) return ADD_LAT;
    if (c == 4'd5 || c == 4'd6) return SHIFT_LAT;
    return 1;
  endfunction

  task automatic model_compute(input logic [31:0] b);
    longint unsigned s;
    m_code = 2'd1;
    m_res  = 32'd0;
    case (m_cmd)
      4'd1: begin
        s = longint'(m_op1) + longint'(b);
        if (s > 64'hFFFF_FFFF) m_code = 2'd2;
        else m_res = 32'(s);
      end
      4'd2: if (b > m_op1) m_code = 2'd2; else m_res = m_op1 - b;
      4'd5: m_res = m_op1 << (b % 32);
      4'd6: m_res = m_op1 >> (b % 32);
      default: m_code = 2'd2;
    endcase
  endtask

  initial begin
    logic was;
    forever begin
      @(posedge c_clk or negedge reset);
      if (!reset) begin
        m_pend = 1'b0; m_err = 0;
        e_resp = 2'd0; e_data = 32'd0; e_busy = 1'b0;
      end else begin
        ecount++;
        was = m_pend;
        e_resp = 2'd0; e_data = 32'd0;
        if (m_pend && ecount == m_c0 + 1) model_compute(req_data_in);
        if (m_pend && ecount >= m_c0 + 2 && ecount <= m_rcyc + 1 &&
            req_cmd_in != 4'd0 && m_err < 255) m_err++;
        if (m_pend && ecount == m_rcyc) begin e_resp = m_code; e_data = m_res; end
        if (m_pend && ecount == m_rcyc + 1) m_pend = 1'b0;
        if (!was && req_cmd_in != 4'd0) begin
          m_pend = 1'b1; m_c0 = ecount; m_cmd = req_cmd_in; m_op1 = req_data_in;
          m_rcyc = ecount + 1 + model_lat(req_cmd_in);
        end
        e_busy = m_pend;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge c_clk);
      chk("cyc_resp", out_resp, e_resp);
      chk("cyc_data", out_data, e_data);
      chk("cyc_busy", busy, e_busy);
`ifdef CALC_PORT_ERRCNT_EN
      chk("cyc_errcnt", proto_err_cnt, m_err);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  // Leaves us #1 after edge E1 (operand2 captured, state EXEC).
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_cmd_in = c; req_data_in = a;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd0; req_data_in = b;
    @(posedge c_clk); #1;
    req_data_in = 32'd0;
  endtask

  task automatic expect_resp(input string n, input int lat, input logic [1:0] r,
                             input logic [31:0] d);
    repeat (lat) begin @(posedge c_clk); #1; end
    chk({n, "_resp"}, out_resp, r);
    chk({n, "_data"}, out_data, d);
    chk({n, "_busy"}, busy, 1'b1);
  endtask

  task automatic expect_idle(input string n);
    @(posedge c_clk); #1;
    chk({n, "_idle_busy"}, busy, 1'b0);
    chk({n, "_idle_resp"}, out_resp, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge c_clk);
    #1;
    chk("rst_resp", out_resp, 2'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
`ifdef CALC_PORT_ERRCNT_EN
    chk("rst_errcnt", proto_err_cnt, 8'd0);
`endif
    #1 reset = 1'b1;

    // NOP stays idle
    @(posedge c_clk); #1;
    chk("nop_busy", busy, 1'b0);

    issue(4'd1, 32'h5, 32'h7);
    expect_resp("add", ADD_LAT, 2'd1, 32'hC);
    expect_idle("add");

    // command during EXEC: dropped, add result unaffected
    issue(4'd1, 32'h100, 32'h23);
    req_cmd_in = 4'd2; req_data_in = 32'hFFFF;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd0; req_data_in = 32'd0;
    expect_resp("viol_add", ADD_LAT - 1, 2'd1, 32'h123);
    expect_idle("viol_add");
    @(posedge c_clk); #1;
    chk("viol_no_second", out_resp, 2'd0);
`ifdef CALC_PORT_ERRCNT_EN
    chk("viol_errcnt", proto_err_cnt, 8'd1);
`endif

    issue(4'd1, 32'hFFFF_FFFF, 32'h1);
    expect_resp("add_ovf", ADD_LAT, 2'd2, 32'h0);
    expect_idle("add_ovf");

    issue(4'd2, 32'h3, 32'h4);
    expect_resp("sub_udf", ADD_LAT, 2'd2, 32'h0);
    expect_idle("sub_udf");

    issue(4'd2, 32'h9, 32'h9);
    expect_resp("sub_eq", ADD_LAT, 2'd1, 32'h0);
    expect_idle("sub_eq");

    issue(4'd5, 32'h1, 32'h21);
    expect_resp("shl", SHIFT_LAT, 2'd1, 32'h2);
    expect_idle("shl");

    // shr, then a command in the RESP cycle that must not be accepted
    issue(4'd6, 32'h8000_0000, 32'd31);
    expect_resp("shr", SHIFT_LAT, 2'd1, 32'h1);
    req_cmd_in = 4'd1; req_data_in = 32'h5;
    @(posedge c_clk); #1;
    req_cmd_in = 4'd0; req_data_in = 32'd0;
    chk("resp_viol_busy", busy, 1'b0);
    chk("resp_viol_resp", out_resp, 2'd0);
`ifdef CALC_PORT_ERRCNT_EN
    chk("resp_viol_errcnt", proto_err_cnt, 8'd2);
`endif

    issue(4'd5, 32'hABCD, 32'h20);
    expect_resp("shl0", SHIFT_LAT, 2'd1, 32'hABCD);
    expect_idle("shl0");

    issue(4'd3, 32'h1234, 32'h0);
    expect_resp("inv", 1, 2'd2, 32'h0);
    expect_idle("inv");

    // reset during EXEC abandons the operation
    issue(4'd1, 32'd100, 32'd200);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_resp", out_resp, 2'd0);
    chk("arst_data", out_data, 32'd0);
`ifdef CALC_PORT_ERRCNT_EN
    chk("arst_errcnt", proto_err_cnt, 8'd0);
`endif
    @(posedge c_clk); #2;
    reset = 1'b1;
    repeat (4) begin
      @(posedge c_clk); #1;
      chk("arst_no_resp", out_resp, 2'd0);
    end
    issue(4'd1, 32'd10, 32'd20);
    expect_resp("post_rst", ADD_LAT, 2'd1, 32'd30);
    expect_idle("post_rst");

    repeat (3) @(posedge c_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
